// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the instruction/data cache memory arbiter:
//   - default memory line-address and cache-line widths
//   - 2-bit arbiter state encoding (IDLE=0, GRANT_I=1, GRANT_D=2)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int LINE_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_e;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one line-wide memory port between an instruction cache (read only)
// and a data cache (read or write-back). Requests are sampled only in IDLE;
// when both caches ask at once, the one not served most recently wins.
// The memory request fields are registered at grant and held until the
// memory answers; the answer (ready + rdata) is steered combinationally to
// the granted cache only. Every transaction is followed by an IDLE cycle.
//
// Ports
//   clk, proc_reset            : clock, synchronous active-high reset
//   ic_mem_read/addr           : icache line read request
//   ic_mem_rdata/ready         : icache response (ready is a 1-cycle pulse)
//   dc_mem_read/write/addr/wdata : dcache read or write-back request
//   dc_mem_rdata/ready         : dcache response (ready is a 1-cycle pulse)
//   mem_read/write/addr/wdata  : shared memory request (registered)
//   mem_rdata/ready            : shared memory response
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              proc_reset,

    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [LINE_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,

    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [LINE_W-1:0] dc_mem_wdata,
    output logic [LINE_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    arb_state_e        state_q;
    // 1 when the data cache held the port most recently, 0 for the icache.
    logic              last_d;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic              dc_req;
    logic              grant_i;
    logic              grant_d;

    // Round-robin pick: the icache wins unless the dcache is also asking and
    // the icache was the last one served.
    // NOTE: combinational blocks use blocking '=' and assign every output on
    // every path, so no latch can be inferred.
    always_comb begin
        dc_req  = dc_mem_read | dc_mem_write;
        grant_i = ic_mem_read & (~dc_req | last_d);
        grant_d = dc_req & ~grant_i;
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q     <= IDLE;
            last_d      <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_i) begin
                        state_q     <= GRANT_I;
                        mem_read_q  <= 1'b1;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= ic_mem_addr;
                        mem_wdata_q <= '0;
                    end else if (grant_d) begin
                        state_q     <= GRANT_D;
                        // A write-back wins over a simultaneous read.
                        mem_read_q  <= dc_mem_read & ~dc_mem_write;
                        mem_write_q <= dc_mem_write;
                        mem_addr_q  <= dc_mem_addr;
                        mem_wdata_q <= dc_mem_wdata;
                    end
                end
                GRANT_I: begin
                    if (mem_ready) begin
                        state_q    <= IDLE;
                        mem_read_q <= 1'b0;
                        last_d     <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (mem_ready) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        last_d      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Simulation-only flag for a dcache asking to read and write at once.
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            assert (!(dc_mem_read && dc_mem_write))
                else $warning("dc_mem_read and dc_mem_write both high; write takes precedence");
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Response steering: only the granted cache sees ready/rdata; in IDLE
    // both stay quiet so a stray mem_ready is never forwarded.
    assign ic_mem_ready = (state_q == GRANT_I) & mem_ready;
    assign dc_mem_ready = (state_q == GRANT_D) & mem_ready;
    assign ic_mem_rdata = (state_q == GRANT_I) ? mem_rdata : '0;
    assign dc_mem_rdata = (state_q == GRANT_D) ? mem_rdata : '0;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, the memory line-address width.
REQ-002 SHALL have parameter LINE_W, default 128, the cache line width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port proc_reset, input, 1, a synchronous, active-high reset.
REQ-005 SHALL have port ic_mem_read, input, 1, the instruction-cache line read request.
REQ-006 SHALL have port ic_mem_addr, input, ADDR_W, the instruction-cache line address.
REQ-007 SHALL have port ic_mem_rdata, output, LINE_W, the line returned to the instruction cache.
REQ-008 SHALL have port ic_mem_ready, output, 1, the instruction-cache completion pulse.
REQ-009 SHALL have port dc_mem_read, input, 1, the data-cache line read request.
REQ-010 SHALL have port dc_mem_write, input, 1, the data-cache write-back request.
REQ-011 SHALL have port dc_mem_addr, input, ADDR_W, the data-cache line address.
REQ-012 SHALL have port dc_mem_wdata, input, LINE_W, the data-cache write-back line.
REQ-013 SHALL have port dc_mem_rdata, output, LINE_W, the line returned to the data cache.
REQ-014 SHALL have port dc_mem_ready, output, 1, the data-cache completion pulse.
REQ-015 SHALL have ports mem_read and mem_write, outputs, 1 each, the shared memory port requests.
REQ-016 SHALL have ports mem_addr (output, ADDR_W) and mem_wdata (output, LINE_W) for the shared memory port.
REQ-017 SHALL have ports mem_rdata (input, LINE_W) and mem_ready (input, 1), the memory response.

Function
REQ-018 SHALL implement FSM states IDLE, GRANT_I and GRANT_D.
REQ-019 In IDLE, SHALL sample requests each cycle; with no request it SHALL remain in IDLE.
REQ-020 In IDLE with exactly one requester, SHALL move to that requester's GRANT state on the next edge.
REQ-021 In IDLE with both requesting, SHALL grant the port not served most recently, using 1-bit register last_d.
REQ-022 On grant, SHALL register mem_addr, mem_wdata, mem_read and mem_write from the winner; these SHALL stay stable until completion.
REQ-023 Latency: mem_read or mem_write SHALL assert in the cycle after the request is seen in IDLE.
REQ-024 An icache grant SHALL drive mem_write=0 and mem_wdata=0.
REQ-025 If dc_mem_read and dc_mem_write are both high, write SHALL take precedence; simulation SHALL flag the condition with an assertion.
REQ-026 In GRANT_x, SHALL forward mem_ready combinationally to x_mem_ready only, in the same cycle.
REQ-027 In GRANT_x, SHALL drive mem_rdata onto x_mem_rdata only; the non-granted port's ready SHALL be 0 and its rdata SHALL be 0.
REQ-028 On mem_ready in GRANT_x, the next state SHALL be IDLE, mem_read/mem_write SHALL deassert, and last_d SHALL be updated.
REQ-029 Each transaction SHALL be followed by at least one IDLE cycle with mem_read=mem_write=0.
REQ-030 A request that deasserts before its grant SHALL be dropped; requests seen in IDLE are the only ones arbitrated.
REQ-031 mem_ready while in IDLE SHALL be ignored and SHALL NOT be forwarded.

Reset
REQ-032 proc_reset SHALL force IDLE, last_d=1, and mem_read, mem_write, mem_addr, mem_wdata, ic_mem_ready and dc_mem_ready to 0 on the next edge.
REQ-033 Reset mid-transaction SHALL abort the grant regardless of mem_ready in the same cycle; no ready pulse SHALL be forwarded in the following cycle.

Structure
REQ-034 SHALL place the state encoding (2-bit: IDLE=0, GRANT_I=1, GRANT_D=2) and the ADDR_W/LINE_W defaults in shared package mem_arb_pkg.
REQ-035 SHALL be a single module with no sub-module; the round-robin pick is inline logic.

Verification
REQ-036 Icache-only: ic_mem_read=1, addr=0x0000010; memory ready after 3 cycles -> mem_read=1 with mem_addr=0x0000010 one cycle after the request; ic_mem_ready pulses 1 cycle with mem_rdata; dc_mem_ready stays 0.
REQ-037 Simultaneous requests after reset: I addr=0x1, D write addr=0x2 -> I is served first, then D is served with mem_write=1 and mem_wdata passed through; an IDLE gap occurs between them.
REQ-038 Sustained contention over 6 transactions -> grants alternate I, D, I, D, I, D.
REQ-039 Reset asserted in GRANT_D in the same cycle as mem_ready=1 -> next cycle is IDLE, all outputs are 0, and dc_mem_ready=0.
REQ-040 Spurious mem_ready=1 in IDLE -> no ready forwarded and no state change.
REQ-041 Both dc_mem_read and dc_mem_write high with addr=0x5 -> mem_write=1, mem_read=0, and the assertion fires.
